// File: rtl/mul12_sequencer_if.sv
// Bundles the request, result and shared-multiplier signals of mul12_sequencer.
// The sequencer side uses the slave modport; the requester/consumer/multiplier side uses master.
// MUL_SEQ_MAC_EN adds the in_acc request bit (multiply-accumulate).
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// valid may not depend on ready, and payload is only meaningful while valid is high.
interface mul12_sequencer_if #(
  parameter int HALF_W = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2*HALF_W-1:0]   in_a;
  logic [2*HALF_W-1:0]   in_b;
`ifdef MUL_SEQ_MAC_EN
  logic                  in_acc;
`endif
  logic [HALF_W-1:0]     mul_a;
  logic [HALF_W-1:0]     mul_b;
  logic [2*HALF_W-1:0]   mul_p;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*HALF_W-1:0]   out_p;
  logic                  busy;
  logic [2:0]            state_dbg;

`ifdef MUL_SEQ_MAC_EN
  modport slave (
    input  in_valid, in_a, in_b, in_acc, mul_p, out_ready,
    output in_ready, mul_a, mul_b, out_valid, out_p, busy, state_dbg
  );
  modport master (
    output in_valid, in_a, in_b, in_acc, mul_p, out_ready,
    input  in_ready, mul_a, mul_b, out_valid, out_p, busy, state_dbg
  );
`else
  modport slave (
    input  in_valid, in_a, in_b, mul_p, out_ready,
    output in_ready, mul_a, mul_b, out_valid, out_p, busy, state_dbg
  );
  modport master (
    output in_valid, in_a, in_b, mul_p, out_ready,
    input  in_ready, mul_a, mul_b, out_valid, out_p, busy, state_dbg
  );
`endif
endinterface

// File: rtl/mul12_sequencer.sv
// mul12_sequencer: builds a 2*HALF_W x 2*HALF_W unsigned product from four
// partial products of one shared external HALF_W x HALF_W combinational multiplier.
// One MULk state per partial product, then DONE holds the result until taken.
// Optional feature macro: MUL_SEQ_MAC_EN (in_acc=1 seeds the accumulator with out_p).
module mul12_sequencer #(
  parameter int HALF_W = 6
) (
  input logic             clk,
  input logic             rst_n,
  mul12_sequencer_if.slave bus
);
  localparam int FW = 2 * HALF_W;
  localparam int PW = 4 * HALF_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL0 = 3'd1,
    MUL1 = 3'd2,
    MUL2 = 3'd3,
    MUL3 = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [HALF_W-1:0] al, ah, bl, bh;
  logic [HALF_W-1:0] mul_a_c, mul_b_c;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     acc_init;
  logic [PW-1:0]     pp_shifted;
  logic [PW-1:0]     out_p_r;
  logic              out_valid_r;
  logic              in_ready_c;
  logic              accept;
  logic              busy_c;

  assign accept = bus.in_valid & in_ready_c;
  assign busy_c = (state == MUL0) | (state == MUL1) | (state == MUL2) | (state == MUL3);

`ifdef MUL_SEQ_MAC_EN
  // Accumulate mode continues from the product currently held in out_p.
  assign acc_init = bus.in_acc ? out_p_r : '0;
`else
  assign acc_init = '0;
`endif

  // Next state, operand mux and weighting of the current partial product.
  always_comb begin
    state_nxt  = state;
    mul_a_c    = '0;
    mul_b_c    = '0;
    pp_shifted = '0;
    in_ready_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_nxt = MUL0;
      end
      MUL0: begin
        mul_a_c    = al;
        mul_b_c    = bl;
        pp_shifted = PW'(bus.mul_p);
        state_nxt  = MUL1;
      end
      MUL1: begin
        mul_a_c    = al;
        mul_b_c    = bh;
        pp_shifted = PW'(bus.mul_p) << HALF_W;
        state_nxt  = MUL2;
      end
      MUL2: begin
        mul_a_c    = ah;
        mul_b_c    = bl;
        pp_shifted = PW'(bus.mul_p) << HALF_W;
        state_nxt  = MUL3;
      end
      MUL3: begin
        mul_a_c    = ah;
        mul_b_c    = bh;
        pp_shifted = PW'(bus.mul_p) << FW;
        state_nxt  = DONE;
      end
      DONE: begin
        // Taking the result frees the block, so a new request can land in the same cycle.
        in_ready_c = bus.out_ready;
        if (bus.out_ready) state_nxt = bus.in_valid ? MUL0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand capture, partial-product accumulation and result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      al          <= '0;
      ah          <= '0;
      bl          <= '0;
      bh          <= '0;
      acc         <= '0;
      out_p_r     <= '0;
      out_valid_r <= 1'b0;
    end else begin
      if (accept) begin
        al  <= bus.in_a[HALF_W-1:0];
        ah  <= bus.in_a[FW-1:HALF_W];
        bl  <= bus.in_b[HALF_W-1:0];
        bh  <= bus.in_b[FW-1:HALF_W];
        acc <= acc_init;
      end else if ((state == MUL0) || (state == MUL1) || (state == MUL2)) begin
        acc <= acc + pp_shifted;
      end
      if (state == MUL3) begin
        out_p_r     <= acc + pp_shifted;
        out_valid_r <= 1'b1;
      end else if ((state == DONE) && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.mul_a     = mul_a_c;
  assign bus.mul_b     = mul_b_c;
  assign bus.out_valid = out_valid_r;
  assign bus.out_p     = out_p_r;
  assign bus.busy      = busy_c;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_mul12_sequencer.sv
// Bench for mul12_sequencer: vector table, hand-written corner sequences and
// random operands against an arithmetic product / accumulate model.
module tb_mul12_sequencer;
  logic clk;
  logic rst_n;

  mul12_sequencer_if #(.HALF_W(6)) bus ();

  mul12_sequencer #(.HALF_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Shared 6x6 multiplier stand-in.
  assign bus.mul_p = 12'(bus.mul_a) * 12'(bus.mul_b);

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic [23:0] p;
  } vec_t;

  int          checks;
  int          errors;
  logic [23:0] exp_q[$];
  logic [23:0] last_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present a request and hold it until accepted; returns just after the accepting edge.
  task automatic start(input logic [11:0] a, input logic [11:0] b, input logic acc,
                       input logic [23:0] exp);
    int n;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
`ifdef MUL_SEQ_MAC_EN
    bus.in_acc    = acc;
`else
    if (acc) $display("note: accumulate requested in a build without it");
`endif
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(bus.in_ready), 32'd1);
    exp_q.push_back(exp);
    @(posedge clk);
  endtask

  // Follow the four multiply cycles and check the completed result.
  task automatic finish(input logic [11:0] a, input logic [11:0] b);
    logic [5:0]  ea[4];
    logic [5:0]  eb[4];
    logic [23:0] e;
    int          k;
    ea = '{a[5:0], a[5:0], a[11:6], a[11:6]};
    eb = '{b[5:0], b[11:6], b[5:0], b[11:6]};
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = 12'($urandom);
    bus.in_b      = 12'($urandom);
    k = 0;
    while (!bus.out_valid && k < 10) begin
      if (k < 4) begin
        chk("mul_a", 32'(bus.mul_a), 32'(ea[k]));
        chk("mul_b", 32'(bus.mul_b), 32'(eb[k]));
      end
      chk("busy_mul", 32'(bus.busy), 32'd1);
      chk("in_ready_mul", 32'(bus.in_ready), 32'd0);
      k++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("latency", 32'(k), 32'd4);
    chk("out_valid_done", 32'(bus.out_valid), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("out_p", 32'(bus.out_p), 32'(e));
    end else begin
      errors++;
      $display("FAIL scoreboard: result with empty expected queue");
    end
    chk("busy_done", 32'(bus.busy), 32'd0);
    chk("mul_ab_done", 32'({bus.mul_a, bus.mul_b}), 32'd0);
  endtask

  // Stall the consumer for n cycles; the result must stay put.
  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_out_p", 32'(bus.out_p), 32'(last_out));
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
  endtask

  // Take the result with no new request; block returns to idle with out_p kept.
  task automatic consume();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("consume_valid", 32'(bus.out_valid), 32'd0);
    chk("consume_in_ready", 32'(bus.in_ready), 32'd1);
    chk("idle_out_p", 32'(bus.out_p), 32'(last_out));
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_p"}, 32'(bus.out_p), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_mul_ab"}, 32'({bus.mul_a, bus.mul_b}), 32'd0);
  endtask

  initial begin
    vec_t        vecs[8];
    logic [11:0] ra, rb;
    logic        racc;
    logic [23:0] prod;

    checks   = 0;
    errors   = 0;
    last_out = '0;

    vecs[0] = '{12'hFFF, 12'hFFF, 24'hFFE001};
    vecs[1] = '{12'h03F, 12'h040, 24'h000FC0};
    vecs[2] = '{12'h005, 12'h007, 24'h000023};
    vecs[3] = '{12'h000, 12'hFFF, 24'h000000};
    vecs[4] = '{12'h800, 12'h800, 24'h400000};
    vecs[5] = '{12'hFFF, 12'h001, 24'h000FFF};
    vecs[6] = '{12'h002, 12'h003, 24'h000006};
    vecs[7] = '{12'h040, 12'h03F, 24'h000FC0};

    // Reset state.
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
`ifdef MUL_SEQ_MAC_EN
    bus.in_acc    = 1'b0;
`endif
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_checks("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table, including 0xFFF*0xFFF and the 0x03F*0x040 operand sequence.
    for (int i = 0; i < 8; i++) begin
      start(vecs[i].a, vecs[i].b, 1'b0, vecs[i].p);
      last_out = vecs[i].p;
      finish(vecs[i].a, vecs[i].b);
      consume();
    end

    // Backpressure for 3 cycles, then release with a same-cycle new request 5x7.
    start(12'hFFF, 12'hFFF, 1'b0, 24'hFFE001);
    last_out = 24'hFFE001;
    finish(12'hFFF, 12'hFFF);
    hold(3);
    @(negedge clk);
    chk("pre_release_out_p", 32'(bus.out_p), 32'h00FFE001);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 12'h005;
    bus.in_b      = 12'h007;
`ifdef MUL_SEQ_MAC_EN
    bus.in_acc    = 1'b0;
`endif
    #1;
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.push_back(24'h000023);
    last_out = 24'h000023;
    @(posedge clk);
    finish(12'h005, 12'h007);
    consume();

    // Reset during MUL2 of 0x123*0x456: request dropped, nothing emitted.
    start(12'h123, 12'h456, 1'b0, 24'h04EDC2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_reset_in_mul2", 32'(bus.state_dbg), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    reset_checks("mid_reset");
    exp_q.delete();
    last_out = '0;
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_no_valid", 32'(bus.out_valid), 32'd0);
    end
    start(12'h002, 12'h003, 1'b0, 24'h000006);
    last_out = 24'h000006;
    finish(12'h002, 12'h003);
    consume();

`ifdef MUL_SEQ_MAC_EN
    // Multiply-accumulate sequence, including wrap past 2^24.
    start(12'h004, 12'h005, 1'b1, 24'h00001A);
    last_out = 24'h00001A;
    finish(12'h004, 12'h005);
    consume();
    start(12'h000, 12'h000, 1'b0, 24'h000000);
    last_out = 24'h000000;
    finish(12'h000, 12'h000);
    consume();
    start(12'hFFF, 12'hFFF, 1'b1, 24'hFFE001);
    last_out = 24'hFFE001;
    finish(12'hFFF, 12'hFFF);
    consume();
    start(12'hFFF, 12'hFFF, 1'b1, 24'hFFC002);
    last_out = 24'hFFC002;
    finish(12'hFFF, 12'hFFF);
    consume();
`endif

    // Random operands against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      ra = 12'($urandom_range(0, 4095));
      rb = 12'($urandom_range(0, 4095));
`ifdef MUL_SEQ_MAC_EN
      racc = 1'($urandom_range(0, 1));
`else
      racc = 1'b0;
`endif
      prod = 24'(ra) * 24'(rb);
      if (racc) prod = prod + last_out;
      start(ra, rb, racc, prod);
      last_out = prod;
      finish(ra, rb);
      hold($urandom_range(0, 2));
      consume();
    end

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
